// File: rtl/condlogic_banked.sv
`default_nettype none
// ============================================================================
// Module   : condlogic_banked
// Purpose  : Execute-stage condition unit. It evaluates the ARM condition
//            field against one of NBANK NZCV flag banks and gates the write
//            enables. It also handles bank-to-bank flag copies and keeps
//            saturating debug counters.
// Revision : 1.0 - initial release
// ============================================================================
module condlogic_banked #(
  parameter int NBANK = 2,
  parameter int CNTW  = 16,
  localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Valid,
  input  logic [3:0]      Cond,
  input  logic [3:0]      ALUFlags,
  input  logic [1:0]      FlagW,
  input  logic            PCS,
  input  logic            RegW,
  input  logic            MemW,
  input  logic            Branch,
  input  logic [BW-1:0]   BankSel,
  input  logic            CopyEn,
  input  logic [BW-1:0]   CopySrc,
  input  logic [BW-1:0]   CopyDst,
  input  logic            ClrStat,
  output logic            PCSrc,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            BranchOut,
  output logic            CondEx,
  output logic [3:0]      Flags,
  output logic [CNTW-1:0] ExecCnt,
  output logic [CNTW-1:0] SquashCnt,
  output logic            UndefSeen
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [3:0]      bank_q [NBANK];
  logic [3:0]      bank_d [NBANK];
  logic [CNTW-1:0] exec_q, exec_d;
  logic [CNTW-1:0] squash_q, squash_d;
  logic            undef_q, undef_d;
  logic [3:0]      copy_val;
  logic            cond_pass;
  logic [1:0]      flag_write;

  // Bank read ports: out-of-range indices read as zero
  always_comb begin
    Flags    = 4'b0000;
    copy_val = 4'b0000;
    for (int i = 0; i < NBANK; i++) begin
      if (BankSel == BW'(i)) Flags    = bank_q[i];
      if (CopySrc == BW'(i)) copy_val = bank_q[i];
    end
  end

  // Condition decode against the selected bank; unknown/1111 fails
  always_comb begin
    logic n, z, c, v, ge;
    {n, z, c, v} = Flags;
    ge        = (n == v);
    cond_pass = 1'b0;
    case (Cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~(c & ~z);
      4'b1010: cond_pass = ge;
      4'b1011: cond_pass = ~ge;
      4'b1100: cond_pass = ~z & ge;
      4'b1101: cond_pass = ~(~z & ge);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Gated control outputs
  always_comb begin
    CondEx     = Valid & cond_pass;
    PCSrc      = PCS & CondEx;
    RegWrite   = RegW & CondEx;
    MemWrite   = MemW & CondEx;
    BranchOut  = Branch & CondEx;
    flag_write = FlagW & {2{CondEx}};
  end

  // Next bank state: copy first, then the instruction write overrides per field
  always_comb begin
    for (int i = 0; i < NBANK; i++) begin
      bank_d[i] = bank_q[i];
      if (CopyEn && (CopyDst == BW'(i)) && (CopySrc != CopyDst))
        bank_d[i] = copy_val;
      if (BankSel == BW'(i)) begin
        if (flag_write[1]) bank_d[i][3:2] = ALUFlags[3:2];
        if (flag_write[0]) bank_d[i][1:0] = ALUFlags[1:0];
      end
    end
  end

  // Next statistics state: clear dominates, counters saturate
  always_comb begin
    exec_d   = exec_q;
    squash_d = squash_q;
    undef_d  = undef_q;
    if (ClrStat) begin
      exec_d   = '0;
      squash_d = '0;
      undef_d  = 1'b0;
    end else if (Valid) begin
      if (CondEx) begin
        if (exec_q != CNT_MAX) exec_d = exec_q + 1'b1;
      end else begin
        if (squash_q != CNT_MAX) squash_d = squash_q + 1'b1;
      end
      if (Cond == 4'b1111) undef_d = 1'b1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBANK; i++) bank_q[i] <= 4'b0000;
      exec_q   <= '0;
      squash_q <= '0;
      undef_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NBANK; i++) bank_q[i] <= bank_d[i];
      exec_q   <= exec_d;
      squash_q <= squash_d;
      undef_q  <= undef_d;
    end
  end

  assign ExecCnt   = exec_q;
  assign SquashCnt = squash_q;
  assign UndefSeen = undef_q;

endmodule
`default_nettype wire

// File: tb/tb_condlogic_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_condlogic_banked
// Purpose  : Directed self-checking bench for condlogic_banked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_condlogic_banked;

  logic       clk = 1'b0;
  logic       reset;
  logic       Valid;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, Branch;
  logic       BankSel, CopyEn, CopySrc, CopyDst, ClrStat;

  logic        PCSrc, RegWrite, MemWrite, BranchOut, CondEx, UndefSeen;
  logic [3:0]  Flags;
  logic [15:0] ExecCnt, SquashCnt;

  logic        PCSrc2, RegWrite2, MemWrite2, BranchOut2, CondEx2, UndefSeen2;
  logic [3:0]  Flags2;
  logic [1:0]  ExecCnt2, SquashCnt2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  condlogic_banked #(.NBANK(2), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .Branch(Branch),
    .BankSel(BankSel), .CopyEn(CopyEn), .CopySrc(CopySrc), .CopyDst(CopyDst),
    .ClrStat(ClrStat), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .BranchOut(BranchOut), .CondEx(CondEx), .Flags(Flags), .ExecCnt(ExecCnt),
    .SquashCnt(SquashCnt), .UndefSeen(UndefSeen)
  );

  condlogic_banked #(.NBANK(2), .CNTW(2)) dut2 (
    .clk(clk), .reset(reset), .Valid(Valid), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .Branch(Branch),
    .BankSel(BankSel), .CopyEn(CopyEn), .CopySrc(CopySrc), .CopyDst(CopyDst),
    .ClrStat(ClrStat), .PCSrc(PCSrc2), .RegWrite(RegWrite2), .MemWrite(MemWrite2),
    .BranchOut(BranchOut2), .CondEx(CondEx2), .Flags(Flags2), .ExecCnt(ExecCnt2),
    .SquashCnt(SquashCnt2), .UndefSeen(UndefSeen2)
  );

  // Reference condition evaluation written as boolean equations
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; leave time 1 past the edge for driving/sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Valid = 0; Cond = 4'b1110; ALUFlags = 0; FlagW = 0;
    PCS = 0; RegW = 0; MemW = 0; Branch = 0;
    BankSel = 0; CopyEn = 0; CopySrc = 0; CopyDst = 0; ClrStat = 0;
  endtask

  // Write a full NZCV pattern into a bank with an always-pass instruction
  task automatic load_bank(input logic b, input logic [3:0] f);
    idle();
    Valid = 1; BankSel = b; ALUFlags = f; FlagW = 2'b11; Cond = 4'b1110;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    Valid = 1; Cond = 4'b0000;
    #1;
    chk("rst_flags", 32'(Flags), 32'h0);
    chk("rst_exec", 32'(ExecCnt), 32'h0);
    chk("rst_squash", 32'(SquashCnt), 32'h0);
    chk("rst_undef", 32'(UndefSeen), 32'h0);
    chk("rst_eq_condex", 32'(CondEx), 32'h0);
    @(negedge clk);
    reset = 0;
    tick();

    // First instruction and back-to-back visibility
    idle();
    Valid = 1; Cond = 4'b1110; ALUFlags = 4'b0100; FlagW = 2'b11;
    RegW = 1; #1;
    chk("al_condex", 32'(CondEx), 32'h1);
    chk("al_regwrite", 32'(RegWrite), 32'h1);
    tick();
    idle(); Valid = 1; Cond = 4'b0000; #1;
    chk("flags_after_write", 32'(Flags), 32'h4);
    chk("eq_pass", 32'(CondEx), 32'h1);
    Cond = 4'b0001; #1;
    chk("ne_fail", 32'(CondEx), 32'h0);

    // Full condition sweep over every flag pattern
    for (int f = 0; f < 16; f++) begin
      load_bank(1'b0, 4'(f));
      Valid = 1;
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c); #1;
        chk($sformatf("cond_c%0d_f%0d", c, f), 32'(CondEx), 32'(ref_cond(4'(c), 4'(f))));
      end
    end
    idle(); Valid = 1; Cond = 4'b1111; tick();
    chk("undef_set", 32'(UndefSeen), 32'h1);

    // Bank isolation
    load_bank(1'b0, 4'b1000);
    load_bank(1'b1, 4'b0010);
    Valid = 1; Cond = 4'b0100; BankSel = 1; #1;
    chk("bank1_mi", 32'(CondEx), 32'h0);
    chk("bank1_flags", 32'(Flags), 32'h2);
    BankSel = 0; #1;
    chk("bank0_mi", 32'(CondEx), 32'h1);

    // Copy colliding with a partial instruction write on the destination
    load_bank(1'b0, 4'b1111);
    Valid = 1; Cond = 4'b1110; BankSel = 1; FlagW = 2'b10; ALUFlags = 4'b0000;
    CopyEn = 1; CopySrc = 0; CopyDst = 1;
    tick();
    idle(); BankSel = 1; #1;
    chk("copy_collide_b1", 32'(Flags), 32'h3);
    BankSel = 0; #1;
    chk("copy_src_kept", 32'(Flags), 32'hF);
    // Plain copy back, and a self-copy that must change nothing
    CopyEn = 1; CopySrc = 1; CopyDst = 0; tick();
    idle(); #1;
    chk("copy_b1_to_b0", 32'(Flags), 32'h3);
    CopyEn = 1; CopySrc = 1; CopyDst = 1; tick();
    idle(); BankSel = 1; #1;
    chk("self_copy_noop", 32'(Flags), 32'h3);

    // Failed condition squashes everything
    idle(); ClrStat = 1; tick();
    idle(); #1;
    chk("clr_exec", 32'(ExecCnt), 32'h0);
    chk("clr_undef", 32'(UndefSeen), 32'h0);
    Valid = 1; Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100;
    RegW = 1; MemW = 1; PCS = 1; Branch = 1; #1;
    chk("fail_gated", 32'({PCSrc, RegWrite, MemWrite, BranchOut, CondEx}), 32'h0);
    tick();
    idle(); #1;
    chk("fail_flags_kept", 32'(Flags), 32'h3);
    chk("fail_squash", 32'(SquashCnt), 32'h1);
    chk("fail_exec", 32'(ExecCnt), 32'h0);
    tick();
    chk("bubble_squash", 32'(SquashCnt), 32'h1);
    chk("bubble_exec", 32'(ExecCnt), 32'h0);

    // Saturation on the narrow-counter instance
    ClrStat = 1; tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      Valid = 1; Cond = 4'b1110; tick();
    end
    chk("sat_exec2", 32'(ExecCnt2), 32'h3);
    chk("nosat_exec16", 32'(ExecCnt), 32'h5);
    Valid = 1; Cond = 4'b1110; ClrStat = 1; tick();
    idle(); #1;
    chk("clr_wins2", 32'(ExecCnt2), 32'h0);
    chk("clr_wins16", 32'(ExecCnt), 32'h0);

    // Asynchronous reset in mid-cycle
    Valid = 1; Cond = 4'b1111; tick();
    idle();
    Valid = 1; Cond = 4'b1110; tick();
    #1; reset = 1; #1;
    chk("async_flags0", 32'(Flags), 32'h0);
    chk("async_exec", 32'(ExecCnt), 32'h0);
    chk("async_undef", 32'(UndefSeen), 32'h0);
    BankSel = 1; #1;
    chk("async_flags1", 32'(Flags), 32'h0);
    @(negedge clk);
    reset = 0;
    idle(); Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    idle(); #1;
    chk("post_rst_flags", 32'(Flags), 32'h4);
    chk("post_rst_exec", 32'(ExecCnt), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
